// File: rtl/arith_req_arbiter_if.sv
// Request/response bundle between two requesters, the shared arithmetic unit and its consumer.
// The master side is the requester/consumer; the slave side is the arbiter.
interface arith_req_arbiter_if #(
    parameter int W = 8
);
    logic         req0_valid;
    logic         req0_ready;
    logic [2:0]   req0_op;
    logic [W-1:0] req0_ina;
    logic [W-1:0] req0_inb;
    logic         req1_valid;
    logic         req1_ready;
    logic [2:0]   req1_op;
    logic [W-1:0] req1_ina;
    logic [W-1:0] req1_inb;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W:0]   rsp_data;
    logic         rsp_err;
    logic         busy;

    modport master (
        output req0_valid, req0_op, req0_ina, req0_inb,
        output req1_valid, req1_op, req1_ina, req1_inb,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_ina, req0_inb,
        input  req1_valid, req1_op, req1_ina, req1_inb,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/arith_req_arbiter.sv
// Round-robin arbiter sharing one add/shift/compare/xor datapath between two requesters.
// Each accepted request is executed in one cycle and held on the response channel until taken.
module arith_req_arbiter #(
    parameter int W       = 8,
    parameter bit RR_INIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    arith_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0]   OP_ADD = 3'd0;
    localparam logic [2:0]   OP_SHL = 3'd1;
    localparam logic [2:0]   OP_LT  = 3'd2;
    localparam logic [2:0]   OP_EQ  = 3'd3;
    localparam logic [2:0]   OP_XOR = 3'd4;
    localparam logic [W-1:0] SHIFT_LIMIT = W'(W);

    state_t       state_q, state_d;
    logic         rrPtr_q, rrPtr_d;
    logic         id_q, id_d;
    logic [2:0]   op_q, op_d;
    logic [W-1:0] ina_q, ina_d;
    logic [W-1:0] inb_q, inb_d;
    logic [W:0]   rspData_q, rspData_d;
    logic         rspErr_q, rspErr_d;

    logic         anyValid;
    logic         grantId;
    logic         req0Ready;
    logic         req1Ready;
    logic [W-1:0] shifted;
    logic [W:0]   result;
    logic         resultErr;

    // Round-robin pointer only breaks ties; a lone requester always wins.
    assign anyValid = bus.req0_valid | bus.req1_valid;
    assign grantId  = (bus.req0_valid & bus.req1_valid) ? rrPtr_q : bus.req1_valid;

    always_comb begin
        shifted   = ina_q << inb_q;
        result    = '0;
        resultErr = 1'b0;
        case (op_q)
            OP_ADD: result = {1'b0, ina_q} + {1'b0, inb_q};
            OP_SHL: if (inb_q < SHIFT_LIMIT) result = {1'b0, shifted};
            OP_LT:  result[0] = (ina_q < inb_q);
            OP_EQ:  result[0] = (ina_q == inb_q);
            OP_XOR: result[0] = ^ina_q;
            default: resultErr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rrPtr_q   <= RR_INIT;
            id_q      <= 1'b0;
            op_q      <= '0;
            ina_q     <= '0;
            inb_q     <= '0;
            rspData_q <= '0;
            rspErr_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rrPtr_q   <= rrPtr_d;
            id_q      <= id_d;
            op_q      <= op_d;
            ina_q     <= ina_d;
            inb_q     <= inb_d;
            rspData_q <= rspData_d;
            rspErr_q  <= rspErr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        rrPtr_d   = rrPtr_q;
        id_d      = id_q;
        op_d      = op_q;
        ina_d     = ina_q;
        inb_d     = inb_q;
        rspData_d = rspData_q;
        rspErr_d  = rspErr_q;
        req0Ready = 1'b0;
        req1Ready = 1'b0;
        case (state_q)
            IDLE: begin
                if (anyValid) begin
                    req0Ready = ~grantId;
                    req1Ready = grantId;
                    id_d      = grantId;
                    op_d      = grantId ? bus.req1_op  : bus.req0_op;
                    ina_d     = grantId ? bus.req1_ina : bus.req0_ina;
                    inb_d     = grantId ? bus.req1_inb : bus.req0_inb;
                    rrPtr_d   = ~grantId;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                rspData_d = result;
                rspErr_d  = resultErr;
                state_d   = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req0_ready = req0Ready;
    assign bus.req1_ready = req1Ready;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = rspData_q;
    assign bus.rsp_err    = rspErr_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_arith_req_arbiter.sv
// Bench for arith_req_arbiter: directed vector table, multi-cycle corner sequences and
// randomized traffic against a transaction-level model.
module tb_arith_req_arbiter;

    typedef struct {
        bit         id;
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] expData;
        bit         expErr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   testsRun = 0;
    int   testsFailed = 0;
    vec_t vecs[14];
    vec_t v;
    int   grants[$];
    int   ids[$];

    // Model state: one outstanding transaction plus the tie-break priority.
    bit   mPending;
    int   mWait;
    bit   mId;
    int   mData;
    bit   mErr;
    bit   mPrio;

    always #5 clk = ~clk;

    arith_req_arbiter_if #(.W(8)) bus();

    arith_req_arbiter #(.W(8), .RR_INIT(1'b0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input bit v0, input logic [2:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                                 input bit v1, input logic [2:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                                 input bit rspReady);
        bus.req0_valid = v0;
        bus.req0_op    = op0;
        bus.req0_ina   = a0;
        bus.req0_inb   = b0;
        bus.req1_valid = v1;
        bus.req1_op    = op1;
        bus.req1_ina   = a1;
        bus.req1_inb   = b1;
        bus.rsp_ready  = rspReady;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void refResult(input int op, input int a, input int b, output int data, output bit err);
        err  = 1'b0;
        data = 0;
        case (op)
            0: data = a + b;
            1: data = (b < 8) ? ((a * (1 << b)) % 256) : 0;
            2: data = (a < b) ? 1 : 0;
            3: data = (a == b) ? 1 : 0;
            4: data = $countones(a) % 2;
            default: err = 1'b1;
        endcase
    endfunction

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 8'hFF, 8'h01, 9'h100, 1'b0};
        vecs[1]  = '{1'b1, 3'd0, 8'h80, 8'h7F, 9'h0FF, 1'b0};
        vecs[2]  = '{1'b0, 3'd1, 8'h81, 8'h01, 9'h002, 1'b0};
        vecs[3]  = '{1'b1, 3'd1, 8'h81, 8'h07, 9'h080, 1'b0};
        vecs[4]  = '{1'b0, 3'd1, 8'h81, 8'h08, 9'h000, 1'b0};
        vecs[5]  = '{1'b1, 3'd1, 8'h81, 8'hFF, 9'h000, 1'b0};
        vecs[6]  = '{1'b0, 3'd2, 8'h03, 8'h05, 9'h001, 1'b0};
        vecs[7]  = '{1'b1, 3'd2, 8'h05, 8'h03, 9'h000, 1'b0};
        vecs[8]  = '{1'b0, 3'd3, 8'hAA, 8'hAA, 9'h001, 1'b0};
        vecs[9]  = '{1'b1, 3'd3, 8'hAA, 8'hAB, 9'h000, 1'b0};
        vecs[10] = '{1'b0, 3'd4, 8'h07, 8'h00, 9'h001, 1'b0};
        vecs[11] = '{1'b1, 3'd4, 8'h0F, 8'h00, 9'h000, 1'b0};
        vecs[12] = '{1'b0, 3'd6, 8'h12, 8'h34, 9'h000, 1'b1};
        vecs[13] = '{1'b1, 3'd7, 8'hFF, 8'hFF, 9'h000, 1'b1};

        rst_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        checkOutput("reset rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("reset busy", 32'(bus.busy), 0);
        checkOutput("reset rsp_id", 32'(bus.rsp_id), 0);
        checkOutput("reset rsp_data", 32'(bus.rsp_data), 0);
        checkOutput("reset rsp_err", 32'(bus.rsp_err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single-requester vectors; rsp_ready is held high so each takes 3 cycles plus one idle.
        for (int i = 0; i < 14; i++) begin
            v = vecs[i];
            @(negedge clk);
            if (v.id) applyStimulus(0, 0, 0, 0, 1, v.op, v.a, v.b, 1);
            else      applyStimulus(1, v.op, v.a, v.b, 0, 0, 0, 0, 1);
            #1;
            checkOutput($sformatf("vec%0d ready", i), 32'(v.id ? bus.req1_ready : bus.req0_ready), 1);
            @(negedge clk);
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
            #1;
            checkOutput($sformatf("vec%0d exec rsp_valid", i), 32'(bus.rsp_valid), 0);
            checkOutput($sformatf("vec%0d exec busy", i), 32'(bus.busy), 1);
            @(negedge clk);
            #1;
            checkOutput($sformatf("vec%0d rsp_valid", i), 32'(bus.rsp_valid), 1);
            checkOutput($sformatf("vec%0d rsp_id", i), 32'(bus.rsp_id), 32'(v.id));
            checkOutput($sformatf("vec%0d rsp_data", i), 32'(bus.rsp_data), 32'(v.expData));
            checkOutput($sformatf("vec%0d rsp_err", i), 32'(bus.rsp_err), 32'(v.expErr));
            @(negedge clk);
            #1;
            checkOutput($sformatf("vec%0d rsp_valid drop", i), 32'(bus.rsp_valid), 0);
        end

        // Both requesters contending from reset must alternate starting with requester 0.
        doReset();
        grants.delete();
        ids.delete();
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            applyStimulus(1, 3'd0, 8'h01, 8'h02, 1, 3'd0, 8'h10, 8'h20, 1);
            #1;
            if (bus.req0_ready) grants.push_back(0);
            if (bus.req1_ready) grants.push_back(1);
            if (bus.rsp_valid) begin
                ids.push_back(int'(bus.rsp_id));
                checkOutput("rr rsp_data", 32'(bus.rsp_data), bus.rsp_id ? 32'h30 : 32'h03);
            end
        end
        checkOutput("rr grant count", 32'(grants.size() >= 4), 1);
        checkOutput("rr rsp count", 32'(ids.size() >= 4), 1);
        for (int k = 0; k < 4; k++) begin
            if (k < grants.size()) checkOutput($sformatf("rr grant%0d", k), 32'(grants[k]), 32'(k % 2));
            if (k < ids.size())    checkOutput($sformatf("rr rsp_id%0d", k), 32'(ids[k]), 32'(k % 2));
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        end

        // Consumer stalls for 5 cycles while requester 1 waits.
        @(negedge clk);
        applyStimulus(1, 3'd0, 8'h05, 8'h06, 0, 0, 0, 0, 0);
        #1;
        checkOutput("stall ready0", 32'(bus.req0_ready), 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 1, 3'd2, 8'h01, 8'h09, 0);
        #1;
        checkOutput("stall exec ready1", 32'(bus.req1_ready), 0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            checkOutput("stall rsp_valid", 32'(bus.rsp_valid), 1);
            checkOutput("stall rsp_id", 32'(bus.rsp_id), 0);
            checkOutput("stall rsp_data", 32'(bus.rsp_data), 32'h00B);
            checkOutput("stall ready1", 32'(bus.req1_ready), 0);
            checkOutput("stall ready0", 32'(bus.req0_ready), 0);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        checkOutput("release rsp_valid", 32'(bus.rsp_valid), 1);
        checkOutput("release ready1", 32'(bus.req1_ready), 0);
        @(negedge clk);
        #1;
        checkOutput("after release rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("after release ready1", 32'(bus.req1_ready), 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        checkOutput("held req rsp_id", 32'(bus.rsp_id), 1);
        checkOutput("held req rsp_data", 32'(bus.rsp_data), 1);
        @(negedge clk);

        // Reset while requester 1's op is executing discards it.
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 1, 3'd0, 8'hFF, 8'hFF, 1);
        #1;
        checkOutput("mid-op ready1", 32'(bus.req1_ready), 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        #1;
        checkOutput("mid-op busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("mid-op rst busy", 32'(bus.busy), 0);
        checkOutput("mid-op rst rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("mid-op rst rsp_id", 32'(bus.rsp_id), 0);
        checkOutput("mid-op rst rsp_data", 32'(bus.rsp_data), 0);
        checkOutput("mid-op rst rsp_err", 32'(bus.rsp_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checkOutput("discarded rsp_valid", 32'(bus.rsp_valid), 0);
        end
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 1, 3'd0, 8'h02, 8'h03, 1);
        #1;
        checkOutput("fresh ready1", 32'(bus.req1_ready), 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        #1;
        checkOutput("fresh rsp_valid", 32'(bus.rsp_valid), 1);
        checkOutput("fresh rsp_id", 32'(bus.rsp_id), 1);
        checkOutput("fresh rsp_data", 32'(bus.rsp_data), 5);

        // Randomized traffic against the transaction model.
        doReset();
        mPending = 1'b0;
        mWait    = 0;
        mPrio    = 1'b0;
        mId      = 1'b0;
        mData    = 0;
        mErr     = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bit         rv0, rv1, rrdy, accept, winner;
            logic [2:0] rop0, rop1;
            logic [7:0] ra0, rb0, ra1, rb1;
            rv0  = ($urandom_range(0, 9) < 6);
            rv1  = ($urandom_range(0, 9) < 6);
            rrdy = ($urandom_range(0, 9) < 7);
            rop0 = 3'($urandom_range(0, 7));
            rop1 = 3'($urandom_range(0, 7));
            ra0  = 8'($urandom);
            rb0  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            ra1  = 8'($urandom);
            rb1  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 9)) : 8'($urandom);
            @(negedge clk);
            applyStimulus(rv0, rop0, ra0, rb0, rv1, rop1, ra1, rb1, rrdy);
            #1;
            accept = !mPending && (rv0 || rv1);
            winner = (rv0 && rv1) ? mPrio : rv1;
            checkOutput("rand ready0", 32'(bus.req0_ready), 32'(accept && !winner));
            checkOutput("rand ready1", 32'(bus.req1_ready), 32'(accept && winner));
            checkOutput("rand busy", 32'(bus.busy), 32'(mPending));
            checkOutput("rand rsp_valid", 32'(bus.rsp_valid), 32'(mPending && mWait == 0));
            if (mPending && mWait == 0) begin
                checkOutput("rand rsp_id", 32'(bus.rsp_id), 32'(mId));
                checkOutput("rand rsp_data", 32'(bus.rsp_data), 32'(mData));
                checkOutput("rand rsp_err", 32'(bus.rsp_err), 32'(mErr));
            end
            if (accept) begin
                mPending = 1'b1;
                mWait    = 1;
                mId      = winner;
                mPrio    = !winner;
                if (winner) refResult(int'(rop1), int'(ra1), int'(rb1), mData, mErr);
                else        refResult(int'(rop0), int'(ra0), int'(rb0), mData, mErr);
            end else if (mPending) begin
                if (mWait > 0) mWait--;
                else if (rrdy) mPending = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
